hpram_user_responder: RTL and testbench
=======================================

Name: hpram_user_responder

Overview:
- Synthesizable stand-in for the HyperRAM memory interface user port; it is the responder side of the cmd/cmd_en/addr/wr_data/rd_data handshake that the hpram_test traffic generator drives.
- Backs the port with an on-chip BRAM so the test generator and LED/error logic can be brought up and regressed without the external HyperRAM, PLL or calibration.
- Reproduces the interface timing: calibration delay, fixed burst length, read latency, byte masks and the inter-command gap.

Parameters:
- ADDR_WIDTH, 22: width of addr. addr is a 32-bit-beat index.
- DATA_WIDTH, 32: user data width (4*DQ_WIDTH).
- MASK_WIDTH, 4: byte-mask width (DATA_WIDTH/8).
- MEM_AW, 10: BRAM depth is 2**MEM_AW words.
- BURST_BEATS, 4: data beats per command (2..16).
- RD_LATENCY, 6: cycles from a read cmd_en to the first rd_data_valid (>=2).
- CMD_GAP, 2: idle cycles after a burst completes before the next command is accepted.
- INIT_CYCLES, 64: cycles after reset before init_calib rises.

Ports:
- clk  in  1  user clock (clk_x1 domain)
- rst  in  1  synchronous reset, active-high
- cmd  in  1  1 = write, 0 = read; sampled with cmd_en
- cmd_en  in  1  command strobe, single cycle
- addr  in  ADDR_WIDTH  start beat address; sampled with cmd_en
- wr_data  in  DATA_WIDTH  write beat data
- data_mask  in  MASK_WIDTH  per-byte write mask; 1 = byte NOT written
- rd_data  out  DATA_WIDTH  read beat data
- rd_data_valid  out  1  rd_data qualifier
- init_calib  out  1  interface ready
- busy  out  1  high whenever a new cmd_en would be dropped
- cmd_drop  out  1  sticky: a cmd_en arrived while busy or before init_calib

Behaviour:
- Reset values: rd_data=0, rd_data_valid=0, init_calib=0, busy=1, cmd_drop=0, state=INIT. BRAM contents are not reset.
- INIT: a counter runs INIT_CYCLES cycles, then init_calib=1 and busy=0, and the state moves to IDLE. init_calib stays high until the next rst.
- IDLE: on cmd_en, latch cmd and base = addr[MEM_AW-1:0], clear the beat counter, and set busy=1 in the next cycle.
  - cmd=1: go to WRITE.
  - cmd=0: go to RD_WAIT.
- WRITE:
  - Beat 0 is wr_data/data_mask in the cmd_en cycle itself. Beats 1..BURST_BEATS-1 follow on the consecutive cycles; no gaps are allowed and no valid is needed.
  - Beat k is written to word (base+k) mod 2**MEM_AW. Byte j is written only if data_mask[j]=0.
  - After the last beat, go to GAP.
- RD_WAIT and READ:
  - The first rd_data_valid occurs exactly RD_LATENCY cycles after the cmd_en cycle.
  - rd_data_valid then stays high for BURST_BEATS consecutive cycles. Beat k = word (base+k) mod 2**MEM_AW.
  - After the last beat, go to GAP.
  - Outside valid cycles, rd_data holds its last value.
- GAP: count CMD_GAP cycles, then go to IDLE. busy drops in the same cycle the state enters IDLE.
- Drops:
  - cmd_en while busy=1, or while init_calib=0, is ignored: no state change, no memory write.
  - Such a cmd_en sets cmd_drop, which is cleared only by rst.
- Address wrap: the beat address wraps modulo 2**MEM_AW. Bits of addr at or above MEM_AW are ignored.
- Read-after-write: a read issued after a write's GAP returns the written data. No same-cycle read/write hazard can occur, because commands are serialized.
- rst asserted mid-burst:
  - Aborts the burst next cycle and returns to INIT.
  - rd_data_valid falls immediately; no partial beats follow.
  - Beats already written remain in memory.
- BRAM: single-port, registered read (1-cycle). The read address is issued RD_LATENCY-1 cycles after cmd_en so that data aligns with rd_data_valid.

Decomposition:
- Package hpram_user_pkg holds:
  - the state enum (INIT, IDLE, WRITE, RD_WAIT, READ, GAP);
  - CMD_WR=1'b1 and CMD_RD=1'b0;
  - the width localparams.
- One sub-module, hpram_bram_bytewe: a parameterized single-port BRAM with per-byte write enable and registered read, so that it infers Gowin BSRAM.

Test Plan:
- Reset release: hold rst for 3 cycles, then release.
  - init_calib=0 and busy=1 for exactly 64 cycles; then init_calib=1 and busy=0.
  - cmd_en at cycle 10 sets cmd_drop=1.
- Write/read burst:
  - Write addr=0x10 with beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 and mask 0.
  - Read addr=0x10 after busy falls.
  - rd_data_valid rises 6 cycles after cmd_en, lasts 4 cycles, and returns the same 4 words in order.
- Byte mask:
  - Write 0xFFFFFFFF to addr 0x20, then write 0xAABBCCDD with data_mask=4'b0101.
  - Readback of word 0x20 = 0xAAFFCCFF.
- Wrap: write a burst at addr=0x3FE with beats A,B,C,D.
  - Words 0x3FE=A, 0x3FF=B, 0x000=C, 0x001=D.
  - addr=0x3FE|(1<<15) reads back the same.
- Drop while busy: issue cmd_en in cycle 2 of a write burst.
  - Memory is unchanged by the dropped command and the burst completes normally.
  - cmd_drop=1 and stays 1 until rst.
- Reset mid-read: assert rst on the second rd_data_valid cycle.
  - The next cycle has rd_data_valid=0, init_calib=0 and busy=1.
  - After re-init, earlier writes still read back correctly.

Source files
------------

// File: rtl/hpram_user_pkg.sv
// Shared types and constants for the HyperRAM user-port responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state enum, command encodings, default widths, counter width.
package hpram_user_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    WRITE   = 3'd2,
    RD_WAIT = 3'd3,
    READ    = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  localparam int DEF_ADDR_WIDTH = 22;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MASK_WIDTH = DEF_DATA_WIDTH / 8;
  localparam int DEF_MEM_AW     = 10;

  // One shared counter covers init delay, beat index, read wait and gap.
  localparam int CNT_W = 16;

endpackage

// File: rtl/hpram_user_responder_if.sv
// HyperRAM user-port bundle: command strobe, address, write data/mask, read data, status.
// Latency: n/a (wires only).
// Backpressure: none on the wire; the responder signals busy and flags dropped commands.
// Modports: master = traffic generator side, slave = memory responder side.
interface hpram_user_responder_if
  import hpram_user_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH = DEF_MASK_WIDTH
) ();

  logic                  cmd;
  logic                  cmd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MASK_WIDTH-1:0] data_mask;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  init_calib;
  logic                  busy;
  logic                  cmd_drop;

  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, init_calib, busy, cmd_drop
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, init_calib, busy, cmd_drop
  );

endinterface

// File: rtl/hpram_bram_bytewe.sv
// Single-port block RAM with per-byte write enable and registered read data.
// Latency: read data appears one cycle after re; writes land on the same edge.
// Backpressure: none; accepts an access every cycle. rdata holds when re is low.
// Ports: clk/rst (rst clears only the output register), we per byte, re, addr, wdata, rdata.
module hpram_bram_bytewe #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int BW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Array has no reset so the tools map it onto block RAM.
  always_ff @(posedge clk) begin
    for (int j = 0; j < BW; j++) begin
      if (we[j]) mem[addr][j*8 +: 8] <= wdata[j*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/hpram_user_responder.sv
// On-chip stand-in for the HyperRAM user port: burst writes/reads into a BRAM with real timing.
// Latency: first rd_data_valid RD_LATENCY cycles after a read cmd_en; BURST_BEATS beats per command.
// Backpressure: busy high from init through burst and CMD_GAP; cmd_en while busy is dropped and flagged sticky.
// Ports: clk, rst (sync, active-high), bus (slave side of hpram_user_responder_if).
module hpram_user_responder
  import hpram_user_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH  = DEF_MASK_WIDTH,
  parameter int MEM_AW      = DEF_MEM_AW,
  parameter int BURST_BEATS = 4,
  parameter int RD_LATENCY  = 6,
  parameter int CMD_GAP     = 2,
  parameter int INIT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst,
  hpram_user_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST_BEATS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CMD_GAP - 1);
  // RD_WAIT ends one cycle before the BRAM read is issued (cmd_en + RD_LATENCY-1),
  // since the registered BRAM output adds the final cycle.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LATENCY - 3);
  localparam state_t RD_FIRST    = (RD_LATENCY == 2) ? READ : RD_WAIT;
  localparam state_t AFTER_BURST = (CMD_GAP == 0) ? IDLE : GAP;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [MEM_AW-1:0]       base, base_nxt, mem_addr;
  logic [MASK_WIDTH-1:0]   mem_we;
  logic                    mem_re;
  logic                    busy;
  logic                    init_calib;
  logic                    rd_valid;
  logic                    cmd_drop;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    addr_unused;

  // Address bits above the BRAM depth are deliberately ignored (wrap).
  assign addr_unused = ^bus.addr[ADDR_WIDTH-1:MEM_AW];

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    base_nxt  = base;
    mem_we    = '0;
    mem_re    = 1'b0;
    mem_addr  = base + MEM_AW'(cnt);
    case (state)
      INIT: begin
        if (cnt == INIT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      IDLE: begin
        cnt_nxt = '0;
        if (bus.cmd_en) begin
          base_nxt = bus.addr[MEM_AW-1:0];
          if (bus.cmd == CMD_RD) begin
            state_nxt = RD_FIRST;
          end else begin
            // Beat 0 rides in the cmd_en cycle itself.
            mem_we    = ~bus.data_mask;
            mem_addr  = bus.addr[MEM_AW-1:0];
            state_nxt = WRITE;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      WRITE: begin
        mem_we = ~bus.data_mask;
        if (cnt == BEAT_LAST) begin
          state_nxt = AFTER_BURST;
          cnt_nxt   = '0;
        end
      end
      RD_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_nxt = READ;
          cnt_nxt   = '0;
        end
      end
      READ: begin
        mem_re = 1'b1;
        if (cnt == BEAT_LAST) begin
          state_nxt = AFTER_BURST;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      cnt        <= '0;
      base       <= '0;
      init_calib <= 1'b0;
      rd_valid   <= 1'b0;
      cmd_drop   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      base     <= base_nxt;
      rd_valid <= mem_re;
      if (state == INIT && state_nxt == IDLE) init_calib <= 1'b1;
      if (bus.cmd_en && (busy || !init_calib)) cmd_drop <= 1'b1;
    end
  end

  hpram_bram_bytewe #(
    .AW (MEM_AW),
    .DW (DATA_WIDTH),
    .BW (MASK_WIDTH)
  ) u_bram (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (bus.wr_data),
    .rdata (mem_rdata)
  );

  assign bus.rd_data       = mem_rdata;
  assign bus.rd_data_valid = rd_valid;
  assign bus.init_calib    = init_calib;
  assign bus.busy          = busy;
  assign bus.cmd_drop      = cmd_drop;

endmodule

// File: tb/tb_hpram_user_responder.sv
// Directed bench for hpram_user_responder: init timing, bursts, masks, wrap, drops, reset mid-read.
// Latency: checks read latency 6, burst 4, gap 2 against hand-computed cycle counts.
// Backpressure: exercises dropped commands during init and during a write burst.
module tb_hpram_user_responder;
  import hpram_user_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hpram_user_responder_if bus ();

  hpram_user_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the most recent burst helpers.
  logic [31:0] rd_q [8];
  int rd_first, rd_cnt, rd_last, rd_idle, wr_busy;

  task automatic apply_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!bus.init_calib && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.init_calib !== 1'b1) begin
      errors++;
      $display("FAIL init_timeout: init_calib=%b after %0d cycles, need 1", bus.init_calib, n);
    end
  endtask

  task automatic do_write(input logic [21:0] a, input logic [31:0] d0, d1, d2, d3,
                          input logic [3:0] m, input bit drop);
    logic [31:0] d [4];
    int n;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int k = 0; k < 4; k++) begin
      bus.cmd       = CMD_WR;
      bus.cmd_en    = (k == 0) || (drop && k == 2);
      bus.addr      = (k == 2 && drop) ? 22'h200 : a;
      bus.wr_data   = d[k];
      bus.data_mask = m;
      @(negedge clk);
    end
    bus.cmd_en    = 1'b0;
    bus.wr_data   = '0;
    bus.data_mask = '1;
    n = 4;
    while (bus.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    wr_busy = n;
  endtask

  task automatic do_read(input logic [21:0] a);
    bus.cmd    = 1'b0;
    bus.cmd_en = 1'b1;
    bus.addr   = a;
    rd_first = -1; rd_cnt = 0; rd_last = -1; rd_idle = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      bus.cmd_en = 1'b0;
      if (bus.rd_data_valid === 1'b1) begin
        if (rd_first < 0) rd_first = k;
        if (rd_cnt < 8) rd_q[rd_cnt] = bus.rd_data;
        rd_cnt++;
        rd_last = k;
      end
      if (bus.busy === 1'b0 && rd_idle < 0) rd_idle = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rd_data !== 32'h0 || bus.rd_data_valid !== 1'b0 || bus.init_calib !== 1'b0 ||
        bus.busy !== 1'b1 || bus.cmd_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rd_data=%h vld=%b calib=%b busy=%b drop=%b, need 0 0 0 1 0",
               bus.rd_data, bus.rd_data_valid, bus.init_calib, bus.busy, bus.cmd_drop);
    end
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (bus.init_calib !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL init_hold cycle %0d: calib=%b busy=%b, need 0 1", i, bus.init_calib, bus.busy);
      end
      bus.cmd_en = (i == 10);
      bus.cmd    = CMD_WR;
      @(negedge clk);
    end
    bus.cmd_en = 1'b0;
    checks++;
    if (bus.init_calib !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL init_done: calib=%b busy=%b, need 1 0", bus.init_calib, bus.busy);
    end
    checks++;
    if (bus.cmd_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_during_init: cmd_drop=%b, need 1", bus.cmd_drop);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] exp [4];
    exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'h33333333; exp[3] = 32'h44444444;
    apply_reset();
    checks++;
    if (bus.cmd_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_cleared_by_rst: cmd_drop=%b, need 0", bus.cmd_drop);
    end
    do_write(22'h10, exp[0], exp[1], exp[2], exp[3], 4'b0000, 1'b0);
    checks++;
    if (wr_busy != 6) begin
      errors++;
      $display("FAIL write_busy_len: busy fell at cycle %0d, need 6", wr_busy);
    end
    do_read(22'h10);
    checks++;
    if (rd_first != 6 || rd_cnt != 4 || rd_last != 9) begin
      errors++;
      $display("FAIL read_timing: first=%0d count=%0d last=%0d, need 6 4 9", rd_first, rd_cnt, rd_last);
    end
    checks++;
    if (rd_idle != 11) begin
      errors++;
      $display("FAIL read_gap: busy fell at cycle %0d, need 11", rd_idle);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL readback beat %0d: got %h, need %h", i, rd_q[i], exp[i]);
      end
    end
    checks++;
    if (bus.rd_data !== 32'h44444444) begin
      errors++;
      $display("FAIL rd_data_hold: got %h, need 44444444", bus.rd_data);
    end
  endtask

  task automatic test_byte_mask();
    do_write(22'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 1'b0);
    do_write(22'h20, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 4'b0101, 1'b0);
    do_read(22'h20);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== 32'hAAFFCCFF) begin
        errors++;
        $display("FAIL byte_mask beat %0d: got %h, need aaffccff", i, rd_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [4];
    exp[0] = 32'hA0A0A0A0; exp[1] = 32'hB1B1B1B1; exp[2] = 32'hC2C2C2C2; exp[3] = 32'hD3D3D3D3;
    do_write(22'h3FE, exp[0], exp[1], exp[2], exp[3], 4'b0000, 1'b0);
    do_read(22'h3FE);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL wrap_3fe beat %0d: got %h, need %h", i, rd_q[i], exp[i]);
      end
    end
    do_read(22'h000);
    checks++;
    if (rd_q[0] !== exp[2] || rd_q[1] !== exp[3]) begin
      errors++;
      $display("FAIL wrap_000: got %h %h, need %h %h", rd_q[0], rd_q[1], exp[2], exp[3]);
    end
    do_read(22'h3FE | (22'd1 << 15));
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL wrap_high_bits beat %0d: got %h, need %h", i, rd_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_drop_busy();
    logic [31:0] pre [4];
    logic [31:0] exp [4];
    pre[0] = 32'h5A000000; pre[1] = 32'h5A000001; pre[2] = 32'h5A000002; pre[3] = 32'h5A000003;
    exp[0] = 32'h01010101; exp[1] = 32'h02020202; exp[2] = 32'h03030303; exp[3] = 32'h04040404;
    checks++;
    if (bus.cmd_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_pre: cmd_drop=%b, need 0", bus.cmd_drop);
    end
    do_write(22'h200, pre[0], pre[1], pre[2], pre[3], 4'b0000, 1'b0);
    do_write(22'h100, exp[0], exp[1], exp[2], exp[3], 4'b0000, 1'b1);
    checks++;
    if (bus.cmd_drop !== 1'b1 || wr_busy != 6) begin
      errors++;
      $display("FAIL drop_busy: cmd_drop=%b busy_len=%0d, need 1 6", bus.cmd_drop, wr_busy);
    end
    do_read(22'h100);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL drop_burst beat %0d: got %h, need %h", i, rd_q[i], exp[i]);
      end
    end
    do_read(22'h200);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_q[i] !== pre[i]) begin
        errors++;
        $display("FAIL drop_untouched beat %0d: got %h, need %h", i, rd_q[i], pre[i]);
      end
    end
    checks++;
    if (bus.cmd_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_sticky: cmd_drop=%b, need 1", bus.cmd_drop);
    end
  endtask

  task automatic test_reset_mid_read();
    int bad;
    bus.cmd    = 1'b0;
    bus.cmd_en = 1'b1;
    bus.addr   = 22'h10;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.cmd_en = 1'b0;
    end
    checks++;
    if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 32'h22222222) begin
      errors++;
      $display("FAIL second_beat: vld=%b data=%h, need 1 22222222", bus.rd_data_valid, bus.rd_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rd_data_valid !== 1'b0 || bus.init_calib !== 1'b0 || bus.busy !== 1'b1 ||
        bus.rd_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_read_reset: vld=%b calib=%b busy=%b data=%h, need 0 0 1 0",
               bus.rd_data_valid, bus.init_calib, bus.busy, bus.rd_data);
    end
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.rd_data_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_partial_beats: %0d valid cycles after reset, need 0", bad);
    end
    apply_reset();
    checks++;
    if (bus.cmd_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_cleared: cmd_drop=%b, need 0", bus.cmd_drop);
    end
    do_read(22'h10);
    checks++;
    if (rd_q[0] !== 32'h11111111 || rd_q[3] !== 32'h44444444 || rd_cnt != 4) begin
      errors++;
      $display("FAIL persist_10: got %h %h count %0d, need 11111111 44444444 4", rd_q[0], rd_q[3], rd_cnt);
    end
    do_read(22'h20);
    checks++;
    if (rd_q[0] !== 32'hAAFFCCFF) begin
      errors++;
      $display("FAIL persist_20: got %h, need aaffccff", rd_q[0]);
    end
    do_read(22'h100);
    checks++;
    if (rd_q[3] !== 32'h04040404) begin
      errors++;
      $display("FAIL persist_100: got %h, need 04040404", rd_q[3]);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd       = 1'b0;
    bus.cmd_en    = 1'b0;
    bus.addr      = '0;
    bus.wr_data   = '0;
    bus.data_mask = '1;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_wrap();
    test_drop_busy();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
